// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition-code register, Cnd evaluation and a
// single-entry valid/ready output register. Stops accepting after a halt.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic [3:0]   dstE,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic [W-1:0] out_valE,
  output logic [W-1:0] out_valA,
  output logic [3:0]   out_dstE,
  output logic         out_cnd,
  output logic         out_err,
  output logic [2:0]   cc,
  output logic         halted
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [W-1:0] EIGHT = W'(8);

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_t;

  logic         accept;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  alu_fn_t      alu_fn;
  logic [W-1:0] alu_res;
  logic         alu_of;
  logic         bad_icode;
  logic         bad_opq;
  logic         bad_cond;
  logic         cc_update;
  logic [2:0]   cc_next;
  logic         zf;
  logic         sf;
  logic         of;
  logic         cnd;
  logic         err;
  logic [W-1:0] vale;
  logic [3:0]   dste;

  assign in_ready = !halted && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  assign bad_icode = (icode > I_POPQ);
  assign bad_opq   = (icode == I_OPQ) && (ifun > 4'd3);
  assign bad_cond  = ((icode == I_RRMOVQ) || (icode == I_JXX)) && (ifun > 4'd6);

  always_comb begin
    alu_a = '0;
    unique case (icode)
      I_RRMOVQ, I_OPQ:             alu_a = valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC;
      I_CALL, I_PUSHQ:             alu_a = -EIGHT;
      I_RET, I_POPQ:               alu_a = EIGHT;
      default:                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
      default:                                                   alu_b = '0;
    endcase
  end

  // Only OPq selects a non-add function; an out-of-range ifun falls back to add.
  always_comb begin
    alu_fn = ALU_ADD;
    if (icode == I_OPQ && !bad_opq) begin
      alu_fn = alu_fn_t'(ifun[1:0]);
    end
  end

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    unique case (alu_fn)
      ALU_ADD: begin
        alu_res = alu_b + alu_a;
        alu_of  = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        alu_of  = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_b[W-1]);
      end
      ALU_AND: alu_res = alu_b & alu_a;
      ALU_XOR: alu_res = alu_b ^ alu_a;
      default: alu_res = '0;
    endcase
  end

  assign cc_update = accept && (icode == I_OPQ) && !bad_opq;
  assign cc_next   = {(alu_res == '0), alu_res[W-1], alu_of};

  // Cnd reads the registered cc, so an OPq accepted on the previous edge is seen.
  always_comb begin
    cnd = 1'b0;
    if ((icode == I_RRMOVQ) || (icode == I_JXX)) begin
      unique case (ifun)
        4'd0:    cnd = 1'b1;
        4'd1:    cnd = (sf ^ of) | zf;
        4'd2:    cnd = sf ^ of;
        4'd3:    cnd = zf;
        4'd4:    cnd = !zf;
        4'd5:    cnd = !(sf ^ of);
        4'd6:    cnd = !(sf ^ of) && !zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  always_comb begin
    err  = bad_icode || bad_opq || bad_cond;
    vale = alu_res;
    dste = dstE;
    if (bad_icode) begin
      vale = '0;
      dste = RNONE;
    end else if ((icode == I_RRMOVQ) && !cnd) begin
      dste = RNONE;
    end else if ((icode == I_HALT) || (icode == I_NOP)) begin
      vale = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= RNONE;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      out_valE  <= vale;
      out_valA  <= valA;
      out_dstE  <= dste;
      out_cnd   <= cnd;
      out_err   <= err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cc     <= 3'b100;
      halted <= 1'b0;
    end else begin
      if (cc_update) begin
        cc <= cc_next;
      end
      if (accept && (icode == I_HALT)) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [3:0]  dstE;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [63:0] out_valE;
  logic [63:0] out_valA;
  logic [3:0]  out_dstE;
  logic        out_cnd;
  logic        out_err;
  logic [2:0]  cc;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  execute_stage #(.W(64), .RNONE(4'hF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE(dstE), .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_valE(out_valE), .out_valA(out_valA),
    .out_dstE(out_dstE), .out_cnd(out_cnd), .out_err(out_err),
    .cc(cc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setInputs(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [3:0] d);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; dstE = d;
  endtask

  // Presents one instruction and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c, input logic [3:0] d);
    int n;
    setInputs(ic, fn, a, b, c, d);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("acceptTimeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    setInputs(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstCc", 64'(cc), 64'h4);
    checkOutput("rstHalted", 64'(halted), 64'd0);
    checkOutput("rstInReady", 64'(in_ready), 64'd1);
    checkOutput("rstDstE", 64'(out_dstE), 64'hF);
    reset = 1'b0;

    // Signed overflow on add, then branches consuming the new flags.
    applyStimulus(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2);
    checkOutput("addValid", 64'(out_valid), 64'd1);
    checkOutput("addValE", out_valE, 64'h8000_0000_0000_0000);
    checkOutput("addCc", 64'(cc), 64'h3);
    checkOutput("addDstE", 64'(out_dstE), 64'h2);
    applyStimulus(4'h7, 4'h2, 64'h0, 64'h0, 64'h400, 4'hF);
    checkOutput("jlCnd", 64'(out_cnd), 64'd0);
    applyStimulus(4'h7, 4'h6, 64'h0, 64'h0, 64'h400, 4'hF);
    checkOutput("jgCnd", 64'(out_cnd), 64'd1);
    checkOutput("jgValE", out_valE, 64'h0);

    // Subtract to zero, then conditional moves on ZF.
    applyStimulus(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h1);
    checkOutput("subValE", out_valE, 64'h0);
    checkOutput("subCc", 64'(cc), 64'h4);
    applyStimulus(4'h2, 4'h4, 64'h55, 64'h0, 64'h0, 4'h3);
    checkOutput("cmovneCnd", 64'(out_cnd), 64'd0);
    checkOutput("cmovneDstE", 64'(out_dstE), 64'hF);
    checkOutput("cmovneValE", out_valE, 64'h55);
    applyStimulus(4'h2, 4'h3, 64'h55, 64'h0, 64'h0, 4'h3);
    checkOutput("cmoveCnd", 64'(out_cnd), 64'd1);
    checkOutput("cmoveDstE", 64'(out_dstE), 64'h3);

    // Stack and address arithmetic leave cc alone.
    applyStimulus(4'hA, 4'h0, 64'hABCD, 64'h100, 64'h0, 4'h4);
    checkOutput("pushValE", out_valE, 64'hF8);
    checkOutput("pushValA", out_valA, 64'hABCD);
    applyStimulus(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
    checkOutput("popValE", out_valE, 64'h108);
    applyStimulus(4'h5, 4'h0, 64'h0, 64'h20, 64'h10, 4'hF);
    checkOutput("mrmovValE", out_valE, 64'h30);
    checkOutput("stackCc", 64'(cc), 64'h4);

    // xor clears all flags; 0-1 gives a negative result without overflow.
    applyStimulus(4'h6, 4'h3, 64'hF0, 64'hFF, 64'h0, 4'h1);
    checkOutput("xorValE", out_valE, 64'h0F);
    checkOutput("xorCc", 64'(cc), 64'h0);
    applyStimulus(4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 4'h1);
    checkOutput("negValE", out_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("negCc", 64'(cc), 64'h2);
    applyStimulus(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF);
    checkOutput("jleCnd", 64'(out_cnd), 64'd1);

    // Backpressure: one entry held stable, then back-to-back transfers.
    @(posedge clk); #1;
    checkOutput("drainValid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    setInputs(4'h3, 4'h0, 64'h0, 64'h0, 64'h11, 4'h4);
    in_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("bpFirstValE", out_valE, 64'h11);
    setInputs(4'h3, 4'h0, 64'h0, 64'h0, 64'h22, 4'h5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bpHoldValE", out_valE, 64'h11);
      checkOutput("bpHoldReady", 64'(in_ready), 64'd0);
    end
    checkOutput("bpHoldDstE", 64'(out_dstE), 64'h4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bpSecondValE", out_valE, 64'h22);
    checkOutput("bpSecondValid", 64'(out_valid), 64'd1);
    setInputs(4'h3, 4'h0, 64'h0, 64'h0, 64'h33, 4'h6);
    @(posedge clk); #1;
    checkOutput("bpThirdValE", out_valE, 64'h33);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("bpEmptyValid", 64'(out_valid), 64'd0);
    checkOutput("bpEmptyHoldValE", out_valE, 64'h33);

    // Invalid icode flows through with an error flag.
    applyStimulus(4'hC, 4'h0, 64'h9, 64'h9, 64'h9, 4'h6);
    checkOutput("badErr", 64'(out_err), 64'd1);
    checkOutput("badValE", out_valE, 64'h0);
    checkOutput("badDstE", 64'(out_dstE), 64'hF);
    checkOutput("badCc", 64'(cc), 64'h2);

    // Halt is delivered, then the stage refuses input until reset.
    applyStimulus(4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    checkOutput("haltHalted", 64'(halted), 64'd1);
    checkOutput("haltValid", 64'(out_valid), 64'd1);
    checkOutput("haltErr", 64'(out_err), 64'd0);
    checkOutput("haltInReady", 64'(in_ready), 64'd0);
    setInputs(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postHaltReady", 64'(in_ready), 64'd0);
    checkOutput("postHaltDrained", 64'(out_valid), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checkOutput("rstHaltCleared", 64'(halted), 64'd0);
    checkOutput("rstCcAgain", 64'(cc), 64'h4);
    checkOutput("rstInReadyAgain", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
